// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU control
// encodings and NZCV flag bit positions.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 32-bit ALU (add/sub/and/or) producing NZCV flags; logical ops clear C and V.
// Subtraction carry is the no-borrow carry of a + ~b + 1.
module alu
   import alu_arb_pkg::*;
(
   input  logic [31:0] srca,
   input  logic [31:0] srcb,
   input  logic [1:0]  alucontrol,
   output logic [31:0] result,
   output logic [3:0]  aluflags
);

   logic [31:0] bmux_s;
   logic [32:0] sum_s;
   logic        arith_s;

   assign bmux_s  = alucontrol[0] ? ~srcb : srcb;
   assign sum_s   = {1'b0, srca} + {1'b0, bmux_s} + {32'd0, alucontrol[0]};
   assign arith_s = ~alucontrol[1];

   // result multiplexer
   always_comb begin
      result = 32'd0;
      case (alucontrol)
         ALU_ADD, ALU_SUB: result = sum_s[31:0];
         ALU_AND:          result = srca & srcb;
         ALU_ORR:          result = srca | srcb;
         default:          result = 32'd0;
      endcase
   end

   assign aluflags[FLAG_N] = result[31];
   assign aluflags[FLAG_Z] = (result == 32'd0);
   assign aluflags[FLAG_C] = arith_s & sum_s[32];
   assign aluflags[FLAG_V] = arith_s & ~(alucontrol[0] ^ srca[31] ^ srcb[31])
                             & (srca[31] ^ sum_s[31]);

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates up to four requesters onto one shared ALU, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin selection; otherwise fixed low-index priority.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0][31:0] req_srca,
   input  logic [NREQ-1:0][31:0] req_srcb,
   input  logic [NREQ-1:0][1:0]  req_ctrl,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [31:0]           rsp_result,
   output logic [3:0]            rsp_flags,
   output logic                  busy,
   output logic [1:0]            grant_id,
   output logic [31:0]           ops_done
);

   state_e          state_r, state_s;
   logic [31:0]     opa_r, opb_r;
   logic [1:0]      ctrl_r;
   logic [1:0]      grant_r, sel_s;
   logic            any_s, hs_s;
   logic [NREQ-1:0] sel_oh_s, grant_oh_s, rsp_valid_r;
   logic [31:0]     alu_res_s, result_r, ops_r;
   logic [3:0]      alu_flg_s, flags_r;
   logic            busy_r;
`ifdef ALU_ARB_RR_EN
   logic [1:0]      last_r;
`endif

   alu u_alu (
      .srca       (opa_r),
      .srcb       (opb_r),
      .alucontrol (ctrl_r),
      .result     (alu_res_s),
      .aluflags   (alu_flg_s)
   );

   // requester selection; loops run from lowest to highest priority so the best candidate lands last
   always_comb begin
      sel_s = 2'd0;
      any_s = |req_valid;
`ifdef ALU_ARB_RR_EN
      for (int d = NREQ; d >= 1; d--) begin
         int idx;
         idx   = (int'(last_r) + d) % NREQ;
         sel_s = req_valid[idx] ? 2'(idx) : sel_s;
      end
`else
      for (int i = NREQ - 1; i >= 0; i--) begin
         sel_s = req_valid[i] ? 2'(i) : sel_s;
      end
`endif
   end

   // one-hot decodes of the selected and granted ports
   always_comb begin
      sel_oh_s   = {NREQ{1'b0}};
      grant_oh_s = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         sel_oh_s[i]   = (sel_s == 2'(i));
         grant_oh_s[i] = (grant_r == 2'(i));
      end
   end

   assign hs_s = (state_r == RESP) && ((rsp_ready & grant_oh_s) != {NREQ{1'b0}});

   // next-state and request-accept decode
   always_comb begin
      state_s   = state_r;
      req_ready = {NREQ{1'b0}};
      case (state_r)
         IDLE: begin
            if (any_s && reset_n) begin
               state_s   = EXEC;
               req_ready = sel_oh_s;
            end else begin
               state_s   = IDLE;
            end
         end
         EXEC:    state_s = RESP;
         RESP: begin
            if (hs_s) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // operand capture, result registers, counters and registered status
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         opa_r       <= 32'd0;
         opb_r       <= 32'd0;
         ctrl_r      <= 2'd0;
         grant_r     <= 2'd0;
         result_r    <= 32'd0;
         flags_r     <= 4'd0;
         ops_r       <= 32'd0;
         busy_r      <= 1'b0;
         rsp_valid_r <= {NREQ{1'b0}};
`ifdef ALU_ARB_RR_EN
         last_r      <= 2'(NREQ - 1);
`endif
      end else begin
         if ((state_r == IDLE) && any_s) begin
            opa_r   <= req_srca[sel_s];
            opb_r   <= req_srcb[sel_s];
            ctrl_r  <= req_ctrl[sel_s];
            grant_r <= sel_s;
`ifdef ALU_ARB_RR_EN
            last_r  <= sel_s;
`endif
         end
         if (state_r == EXEC) begin
            result_r <= alu_res_s;
            flags_r  <= alu_flg_s;
         end
         if (hs_s) begin
            ops_r <= ops_r + 32'd1;
         end
         busy_r      <= (state_s != IDLE);
         rsp_valid_r <= (state_s == RESP) ? grant_oh_s : {NREQ{1'b0}};
      end
   end

   assign rsp_valid  = rsp_valid_r;
   assign rsp_result = result_r;
   assign rsp_flags  = flags_r;
   assign busy       = busy_r;
   assign grant_id   = grant_r;
   assign ops_done   = ops_r;

endmodule
